// File: rtl/img_mem_arbiter.sv
// Arbiter for the single-port image RAM: VGA fetches win over equalizer accesses.
// One access per cycle; read data is returned two edges after the request is sampled.
module img_mem_arbiter #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 8,
   parameter int STARVE_LIM = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic [DATA_W-1:0] disp_data,
   output logic              disp_valid,
   input  logic              eq_req,
   input  logic              eq_we,
   input  logic [ADDR_W-1:0] eq_addr,
   input  logic [DATA_W-1:0] eq_wdata,
   output logic              eq_gnt,
   output logic [DATA_W-1:0] eq_rdata,
   output logic              eq_rvalid,
   input  logic              starve_clr,
   output logic              eq_starved,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = $clog2(STARVE_LIM + 1);
   localparam logic [CNT_W-1:0] LIM_C   = CNT_W'(STARVE_LIM);
   localparam logic [CNT_W-1:0] LIM_M1  = CNT_W'(STARVE_LIM - 1);

   localparam logic [1:0] TAG_NONE = 2'd0;
   localparam logic [1:0] TAG_DISP = 2'd1;
   localparam logic [1:0] TAG_EQR  = 2'd2;

   typedef enum logic [1:0] {S_IDLE, S_DISP, S_EQ} state_t;

   state_t           state, state_nxt;
   logic [1:0]       tag_p0, tag_p1;
   logic [CNT_W-1:0] wait_cnt;
   logic             wait_cyc;
   logic             starve_set;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = S_IDLE;
      if (disp_req)    state_nxt = S_DISP;
      else if (eq_req) state_nxt = S_EQ;
   end

   always_comb begin
      eq_gnt = (state == S_EQ);
   end

   // Stage p0: memory command issued together with the owner tag of the access
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         tag_p0    <= TAG_NONE;
      end else begin
         case (state_nxt)
            S_DISP: begin
               mem_en   <= 1'b1;
               mem_we   <= 1'b0;
               mem_addr <= disp_addr;
               tag_p0   <= TAG_DISP;
            end
            S_EQ: begin
               mem_en    <= 1'b1;
               mem_we    <= eq_we;
               mem_addr  <= eq_addr;
               mem_wdata <= eq_wdata;
               tag_p0    <= eq_we ? TAG_NONE : TAG_EQR;
            end
            default: begin
               mem_en <= 1'b0;
               mem_we <= 1'b0;
               tag_p0 <= TAG_NONE;
            end
         endcase
      end
   end

   // Stage p1: tag lines up with the RAM read data; p2: route to the owner
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_p1     <= TAG_NONE;
         disp_valid <= 1'b0;
         disp_data  <= '0;
         eq_rvalid  <= 1'b0;
         eq_rdata   <= '0;
      end else begin
         tag_p1     <= tag_p0;
         disp_valid <= (tag_p1 == TAG_DISP);
         eq_rvalid  <= (tag_p1 == TAG_EQR);
         if (tag_p1 == TAG_DISP) disp_data <= mem_rdata;
         if (tag_p1 == TAG_EQR)  eq_rdata  <= mem_rdata;
      end
   end

   // Starvation only fires on the transition into the limit, so a saturated
   // counter does not keep re-asserting the flag against starve_clr.
   always_comb begin
      wait_cyc   = eq_req && !eq_gnt;
      starve_set = wait_cyc && (wait_cnt == LIM_M1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt   <= '0;
         eq_starved <= 1'b0;
      end else begin
         if (eq_gnt)                          wait_cnt <= '0;
         else if (wait_cyc && wait_cnt != LIM_C) wait_cnt <= wait_cnt + 1'b1;
         if (starve_set)      eq_starved <= 1'b1;
         else if (starve_clr) eq_starved <= 1'b0;
      end
   end

endmodule

// File: tb/tb_img_mem_arbiter.sv
// Bench for img_mem_arbiter: directed scenarios plus random traffic against a
// transaction-level model (per-edge access records, shadow memory, wait count).
module tb_img_mem_arbiter;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;
   localparam int LIM    = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              disp_req, eq_req, eq_we, starve_clr;
   logic [ADDR_W-1:0] disp_addr, eq_addr;
   logic [DATA_W-1:0] eq_wdata;
   logic [DATA_W-1:0] disp_data, eq_rdata, mem_wdata, mem_rdata;
   logic              disp_valid, eq_gnt, eq_rvalid, eq_starved, mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;

   img_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIM(LIM)) dut (
      .clk(clk), .rst_n(rst_n),
      .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
      .eq_req(eq_req), .eq_we(eq_we), .eq_addr(eq_addr), .eq_wdata(eq_wdata),
      .eq_gnt(eq_gnt), .eq_rdata(eq_rdata), .eq_rvalid(eq_rvalid),
      .starve_clr(starve_clr), .eq_starved(eq_starved),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   logic [DATA_W-1:0] ram    [0:65535];
   logic [DATA_W-1:0] shadow [0:65535];

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata     <= ram[mem_addr];
      end
   end

   // kind: 0 none, 1 display read, 2 eq read, 3 eq write
   typedef struct {
      int                kind;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [DATA_W-1:0] rdata;
   } rec_t;

   rec_t              r0, r1, r2;
   int                waitc;
   logic              starved_m;
   logic [DATA_W-1:0] exp_dd, exp_ed;
   int                checks = 0;
   int                errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic reset_model();
      r0 = '{0, '0, '0, '0};
      r1 = r0;
      r2 = r0;
      waitc = 0;
      starved_m = 1'b0;
      exp_dd = '0;
      exp_ed = '0;
   endtask

   task automatic model_edge();
      logic gnt_now, set;
      if (!rst_n) begin
         reset_model();
         return;
      end
      gnt_now = (r0.kind >= 2);
      set = 1'b0;
      if (gnt_now) waitc = 0;
      else if (eq_req && waitc < LIM) begin
         waitc++;
         set = (waitc == LIM);
      end
      if (set) starved_m = 1'b1;
      else if (starve_clr) starved_m = 1'b0;
      r2 = r1;
      r1 = r0;
      if (disp_req) r0 = '{1, disp_addr, '0, shadow[disp_addr]};
      else if (eq_req) begin
         r0 = '{eq_we ? 3 : 2, eq_addr, eq_wdata, shadow[eq_addr]};
         if (eq_we) shadow[eq_addr] = eq_wdata;
      end else r0 = '{0, '0, '0, '0};
      if (r2.kind == 1) exp_dd = r2.rdata;
      if (r2.kind == 2) exp_ed = r2.rdata;
   endtask

   task automatic check_all();
      chk("mem_en", mem_en, r0.kind != 0);
      chk("mem_we", mem_we, r0.kind == 3);
      if (r0.kind != 0) chk("mem_addr", mem_addr, r0.addr);
      if (r0.kind >= 2) chk("mem_wdata", mem_wdata, r0.wdata);
      chk("eq_gnt", eq_gnt, r0.kind >= 2);
      chk("disp_valid", disp_valid, r2.kind == 1);
      chk("disp_data", disp_data, exp_dd);
      chk("eq_rvalid", eq_rvalid, r2.kind == 2);
      chk("eq_rdata", eq_rdata, exp_ed);
      chk("eq_starved", eq_starved, starved_m);
   endtask

   task automatic check_zero();
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_disp_data", disp_data, 0);
      chk("rst_disp_valid", disp_valid, 0);
      chk("rst_eq_gnt", eq_gnt, 0);
      chk("rst_eq_rdata", eq_rdata, 0);
      chk("rst_eq_rvalid", eq_rvalid, 0);
      chk("rst_eq_starved", eq_starved, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic idle_inputs();
      disp_req = 1'b0;
      eq_req = 1'b0;
      eq_we = 1'b0;
      starve_clr = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      disp_addr = '0;
      eq_addr = '0;
      eq_wdata = '0;
      mem_rdata = '0;
      for (int i = 0; i < 65536; i++) begin
         ram[i] = DATA_W'($urandom);
         shadow[i] = ram[i];
      end
      ram[16'h1234] = 8'h5A;
      shadow[16'h1234] = 8'h5A;
      reset_model();
      tick();
      tick();
      check_zero();
      rst_n = 1'b1;

      // single display fetch
      disp_req = 1'b1;
      disp_addr = 16'h1234;
      tick();
      disp_req = 1'b0;
      tick();
      tick();
      chk("disp_5a", disp_data, 8'h5A);
      tick();

      // display holds off the equalizer for 3 cycles
      disp_req = 1'b1;
      eq_req = 1'b1;
      eq_we = 1'b0;
      eq_addr = 16'h0042;
      for (int i = 0; i < 3; i++) begin
         disp_addr = ADDR_W'($urandom);
         tick();
      end
      disp_req = 1'b0;
      tick();
      eq_req = 1'b0;
      tick();
      tick();

      // write then read back through the equalizer port
      eq_req = 1'b1;
      eq_we = 1'b1;
      eq_addr = 16'h00FF;
      eq_wdata = 8'hA5;
      tick();
      eq_we = 1'b0;
      tick();
      eq_req = 1'b0;
      tick();
      tick();
      chk("eq_rd_a5", eq_rdata, 8'hA5);
      tick();

      // alternating owners every cycle
      for (int i = 0; i < 8; i++) begin
         disp_req = (i % 2 == 0);
         eq_req = (i % 2 == 1);
         eq_we = 1'b0;
         disp_addr = ADDR_W'($urandom);
         eq_addr = ADDR_W'($urandom);
         tick();
      end
      idle_inputs();
      tick();
      tick();
      tick();

      // starvation, sticky until cleared
      disp_req = 1'b1;
      eq_req = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      chk("starved_set", eq_starved, 1);
      disp_req = 1'b0;
      tick();
      eq_req = 1'b0;
      tick();
      tick();
      starve_clr = 1'b1;
      tick();
      starve_clr = 1'b0;
      tick();
      chk("starved_clr", eq_starved, 0);

      // set wins over a simultaneous clear
      disp_req = 1'b1;
      eq_req = 1'b1;
      starve_clr = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk("starved_setwins", eq_starved, 1);
      idle_inputs();
      tick();
      starve_clr = 1'b1;
      tick();
      starve_clr = 1'b0;
      tick();

      // asynchronous reset with a fetch in flight
      disp_req = 1'b1;
      disp_addr = 16'h1234;
      tick();
      disp_req = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_zero();
      reset_model();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) tick();

      // random traffic with a small address window to exercise read-after-write
      for (int i = 0; i < 400; i++) begin
         disp_req = ($urandom_range(0, 9) < 3);
         eq_req = ($urandom_range(0, 1) == 1);
         eq_we = ($urandom_range(0, 1) == 1);
         disp_addr = ADDR_W'($urandom_range(0, 15));
         eq_addr = ADDR_W'($urandom_range(0, 15));
         eq_wdata = DATA_W'($urandom);
         starve_clr = ($urandom_range(0, 19) == 0);
         tick();
      end
      idle_inputs();
      tick();
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/img_mem_arbiter.md
IMG_MEM_ARBITER -- requirements
Module: img_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, SHALL set the image memory address width (256x256 pixels).
REQ-002 Parameter DATA_W, default 8, SHALL set the pixel data width.
REQ-003 Parameter STARVE_LIM, default 1024, SHALL set the equalizer wait-cycle limit before the starve flag is raised.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-006 disp_req  in  1  SHALL be the VGA pixel-fetch read request.
REQ-007 disp_addr  in  ADDR_W  SHALL be the VGA fetch address, {Y[7:0],X[7:0]}.
REQ-008 disp_data  out  DATA_W  SHALL be the VGA read data.
REQ-009 disp_valid  out  1  SHALL be the single-cycle qualifier for disp_data.
REQ-010 eq_req  in  1  SHALL be the equalizer access request, held until granted.
REQ-011 eq_we  in  1  SHALL select write (1) or read (0) for the equalizer access.
REQ-012 eq_addr  in  ADDR_W  SHALL be the equalizer address.
REQ-013 eq_wdata  in  DATA_W  SHALL be the equalizer write data.
REQ-014 eq_gnt  out  1  SHALL pulse for one cycle when the equalizer access is accepted.
REQ-015 eq_rdata  out  DATA_W  SHALL be the equalizer read data.
REQ-016 eq_rvalid  out  1  SHALL be the single-cycle qualifier for eq_rdata.
REQ-017 starve_clr  in  1  SHALL clear the starve flag.
REQ-018 eq_starved  out  1  SHALL be the sticky starvation flag.
REQ-019 mem_en, mem_we  out  1 each; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W  SHALL drive the single-port synchronous image RAM.
REQ-020 mem_rdata  in  DATA_W  SHALL be the RAM read data, valid one cycle after mem_en.

Function
REQ-021 Arbitration SHALL be evaluated at every rising edge; disp_req SHALL have absolute priority over eq_req.
REQ-022 The FSM SHALL have states IDLE, DISP and EQ; the next state SHALL be DISP if disp_req=1, else EQ if eq_req=1, else IDLE.
REQ-023 mem_en, mem_we, mem_addr and mem_wdata SHALL be registered outputs; in DISP they SHALL carry en=1, we=0 and disp_addr; in EQ en=1, we=eq_we, eq_addr and eq_wdata; in IDLE en=0 and we=0.
REQ-024 eq_gnt SHALL be high in exactly the cycle the FSM is in EQ; the requester SHALL drop or update eq_req after a cycle in which eq_gnt=1.
REQ-025 A 2-stage owner tag pipeline (NONE/DISP/EQ-read) SHALL route mem_rdata.
REQ-026 A request sampled at edge N SHALL yield data and its valid at edge N+2: disp_valid for DISP, eq_rvalid for EQ reads, none for EQ writes.
REQ-027 Back-to-back requests SHALL be pipelined at one access per cycle, with no bubble on an owner switch.
REQ-028 The wait counter SHALL count cycles with eq_req=1 and eq_gnt=0, reset to 0 on grant, and saturate at STARVE_LIM.
REQ-029 eq_starved SHALL set when the wait counter reaches STARVE_LIM and remain set until starve_clr=1; if set and clear occur in the same cycle, set SHALL win.
REQ-030 disp_data and eq_rdata SHALL hold their last value while their valid is low.

Reset
REQ-031 On rst_n=0 all outputs SHALL go to 0 immediately: mem_en, mem_we, mem_addr, mem_wdata, disp_data, disp_valid, eq_gnt, eq_rdata, eq_rvalid and eq_starved.
REQ-032 On rst_n=0 the FSM SHALL go to IDLE, the tag pipeline to NONE and the wait counter to 0.
REQ-033 Reset asserted mid-access SHALL discard in-flight tags, so no valid pulse is emitted after reset release.

Verification
REQ-034 Scenario: disp_req=1, disp_addr=0x1234 for one cycle, with the RAM model returning 0x5A -> mem_addr=0x1234 one cycle later, then disp_valid=1 and disp_data=0x5A at N+2.
REQ-035 Scenario: disp_req and eq_req both asserted for 3 cycles, then disp_req low -> eq_gnt=0 for those 3 cycles, then eq_gnt=1 in the 4th; the wait counter reads 3 before the grant.
REQ-036 Scenario: eq write of 0xA5 to 0x00FF, then an eq read of 0x00FF -> mem_we=1 then 0; eq_rvalid=1 only for the read, with eq_rdata=0xA5; disp_valid stays 0 throughout.
REQ-037 Scenario: alternating DISP/EQ-read every cycle for 8 cycles -> 8 mem_en cycles with no gaps, and the valids alternate correctly at +2 latency.
REQ-038 Scenario: STARVE_LIM=4, eq_req held with disp_req=1 for 6 cycles -> eq_starved=1 after the 4th wait cycle, held until starve_clr, then 0.
REQ-039 Scenario: rst_n pulsed low one cycle after disp_req -> all outputs 0 asynchronously, and no disp_valid pulse after release.
